// File: rtl/ysyx_icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Imported by the cache top and its storage array.
package ysyx_icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESP   = 2'd2
  } ysyx_icache_state_t;

  localparam int ICACHE_SETS       = 16;
  localparam int ICACHE_LINE_WORDS = 4;

  // fence.i encoding (MISC-MEM opcode, funct3 = 001)
  localparam logic [31:0] FENCE_I_INST = 32'h0000_100F;

endpackage

// File: rtl/ysyx_icache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read by index,
// a per-word data write port, a tag/valid write port and a flush-all input.
module ysyx_icache_array
  import ysyx_icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = ICACHE_SETS,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  localparam int IDX_W     = $clog2(SETS),
  localparam int WORD_W    = $clog2(LINE_WORDS),
  localparam int TAG_W     = ADDR_W - IDX_W - WORD_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [WORD_W-1:0] rd_word,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic              data_we,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tag_we,
  input  logic              tag_valid,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              flush
);

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS][LINE_WORDS];

  // Flush wins over a same-cycle tag write so a late fence.i never leaves a stale line valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[wr_index] <= tag_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[wr_index] <= wr_tag;
    end
    if (data_we) begin
      data_q[wr_index][wr_word] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_word];

endmodule

// File: rtl/ysyx_icache.sv
// Direct-mapped read-only instruction cache: hit lookup, sequential line refill
// over the arbiter IFU port, hit/miss counters and fence.i invalidation.
//
// state  | meaning
// IDLE   | waiting for a fetch; lookup and tag compare happen here
// REFILL | fetching the line one beat at a time from the bus
// RESP   | one-cycle response pulse to the IFU
module ysyx_icache
  import ysyx_icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = ICACHE_SETS,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_pc,
  input  logic              ifu_req,
  output logic [DATA_W-1:0] ifu_inst_o,
  output logic              ifu_valid_o,
  input  logic              fence_i,
  output logic [ADDR_W-1:0] bus_araddr_o,
  output logic              bus_arvalid_o,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int TAG_W  = ADDR_W - IDX_W - WORD_W - 2;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

  ysyx_icache_state_t state, state_n;

  logic [TAG_W-1:0]  lat_tag;
  logic [IDX_W-1:0]  lat_index;
  logic [WORD_W-1:0] lat_word;
  logic [WORD_W-1:0] beat;
  logic              poison;
  logic [DATA_W-1:0] resp_q;
  logic [31:0]       hit_cnt, miss_cnt;

  logic [WORD_W-1:0] pc_word;
  logic [IDX_W-1:0]  pc_index;
  logic [TAG_W-1:0]  pc_tag;
  logic              unused_pc_offset;

  logic              arr_valid;
  logic [TAG_W-1:0]  arr_tag;
  logic [DATA_W-1:0] arr_data;
  logic              lookup_hit;
  logic              data_we, tag_we, hit_inc, miss_inc;

  assign pc_word          = ifu_pc[2 +: WORD_W];
  assign pc_index         = ifu_pc[2 + WORD_W +: IDX_W];
  assign pc_tag           = ifu_pc[ADDR_W-1 -: TAG_W];
  assign unused_pc_offset = ^ifu_pc[1:0];

  ysyx_icache_array #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (pc_index),
    .rd_word   (pc_word),
    .rd_valid  (arr_valid),
    .rd_tag    (arr_tag),
    .rd_data   (arr_data),
    .wr_index  (lat_index),
    .data_we   (data_we),
    .wr_word   (beat),
    .wr_data   (bus_rdata),
    .tag_we    (tag_we),
    .tag_valid (!poison && !fence_i),
    .wr_tag    (lat_tag),
    .flush     (fence_i)
  );

  // A fence.i arriving with the lookup forces a miss.
  assign lookup_hit = arr_valid && (arr_tag == pc_tag) && !fence_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    bus_arvalid_o = 1'b0;
    bus_araddr_o  = '0;
    ifu_valid_o   = 1'b0;
    data_we       = 1'b0;
    tag_we        = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    case (state)
      IDLE: begin
        if (ifu_req) begin
          if (lookup_hit) begin
            hit_inc = 1'b1;
            state_n = RESP;
          end else begin
            miss_inc = 1'b1;
            state_n  = REFILL;
          end
        end
      end
      REFILL: begin
        bus_arvalid_o = 1'b1;
        bus_araddr_o  = {lat_tag, lat_index, beat, 2'b00};
        if (bus_rvalid) begin
          data_we = 1'b1;
          if (beat == LAST_BEAT) begin
            tag_we  = 1'b1;
            state_n = RESP;
          end
        end
      end
      RESP: begin
        ifu_valid_o = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_tag   <= '0;
      lat_index <= '0;
      lat_word  <= '0;
      beat      <= '0;
      poison    <= 1'b0;
      resp_q    <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      if (hit_inc) begin
        resp_q  <= arr_data;
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (miss_inc) begin
        lat_tag   <= pc_tag;
        lat_index <= pc_index;
        lat_word  <= pc_word;
        beat      <= '0;
        miss_cnt  <= miss_cnt + 32'd1;
      end
      if (state == REFILL && bus_rvalid) begin
        beat <= beat + 1'b1;
        if (beat == lat_word) begin
          resp_q <= bus_rdata;
        end
      end
      // RESP always returns to IDLE, so clearing here is clearing on IDLE entry.
      if (state == REFILL && fence_i) begin
        poison <= 1'b1;
      end else if (state == RESP) begin
        poison <= 1'b0;
      end
    end
  end

  assign ifu_inst_o = resp_q;
  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;

endmodule

// File: tb/tb_ysyx_icache.sv
// Self-checking bench for ysyx_icache: directed vector table, hand-written
// multi-cycle sequences, and randomized fetches against a behavioural cache model.
module tb_ysyx_icache;

  localparam int SETS = 16;
  localparam int LW   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ifu_pc = '0;
  logic        ifu_req = 1'b0;
  logic [31:0] ifu_inst_o;
  logic        ifu_valid_o;
  logic        fence_i = 1'b0;
  logic [31:0] bus_araddr_o;
  logic        bus_arvalid_o;
  logic [31:0] bus_rdata = '0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] hit_cnt_o, miss_cnt_o;

  always #5 clk = ~clk;

  ysyx_icache #(.ADDR_W(32), .DATA_W(32), .SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_pc       (ifu_pc),
    .ifu_req      (ifu_req),
    .ifu_inst_o   (ifu_inst_o),
    .ifu_valid_o  (ifu_valid_o),
    .fence_i      (fence_i),
    .bus_araddr_o (bus_araddr_o),
    .bus_arvalid_o(bus_arvalid_o),
    .bus_rdata    (bus_rdata),
    .bus_rvalid   (bus_rvalid),
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Backing memory: the first line holds 0x11..0x44, everything else is address-derived.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h8000000) return 32'h11 * (32'(a[3:2]) + 32'd1);
    return a ^ 32'h5A5A_1234;
  endfunction

  // Bus responder: each beat answers lat cycles after the address is first seen.
  int          bus_lat = 1;
  int          bus_wait = 0;
  bit          bus_busy = 0;
  bit          stray_req = 0;
  int          beat_count = 0;
  logic [31:0] cur_addr = '0;
  logic [31:0] addr_q[$];

  always @(negedge clk) begin
    bus_rvalid = 1'b0;
    if (!rst) begin
      bus_busy = 0;
    end else if (stray_req) begin
      stray_req  = 0;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'hDEAD_BEEF;
    end else if (bus_busy) begin
      bus_wait--;
      if (bus_wait <= 0) begin
        bus_rvalid = 1'b1;
        bus_rdata  = mem_word(cur_addr);
        bus_busy   = 0;
        beat_count++;
      end
    end else if (bus_arvalid_o) begin
      cur_addr = bus_araddr_o;
      addr_q.push_back(bus_araddr_o);
      if (bus_lat == 0) begin
        bus_rvalid = 1'b1;
        bus_rdata  = mem_word(cur_addr);
        beat_count++;
      end else begin
        bus_busy = 1;
        bus_wait = bus_lat;
      end
    end
  end

  task automatic do_fetch(input logic [31:0] pc, input int fence_cyc, input int lat,
                          output logic [31:0] inst, output int vcyc, output int nvalid,
                          output int nbeats);
    bus_lat = lat;
    addr_q.delete();
    beat_count = 0;
    nvalid = 0;
    vcyc = -1;
    inst = '0;
    @(negedge clk);
    ifu_pc  = pc;
    ifu_req = 1'b1;
    fence_i = (fence_cyc == 0);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      fence_i = (fence_cyc == c);
      if (ifu_valid_o) begin
        nvalid++;
        if (vcyc < 0) begin
          vcyc    = c;
          inst    = ifu_inst_o;
          ifu_req = 1'b0;
        end
      end
      if (vcyc >= 0 && c >= vcyc + 2) break;
    end
    fence_i = 1'b0;
    ifu_req = 1'b0;
    nbeats  = beat_count;
  endtask

  task automatic pulse_fence();
    @(negedge clk);
    fence_i = 1'b1;
    @(negedge clk);
    fence_i = 1'b0;
  endtask

  int exp_hits = 0;
  int exp_miss = 0;

  task automatic fetch_and_check(input string name, input logic [31:0] pc, input int fence_cyc,
                                 input int lat, input bit miss, input logic [31:0] exp_inst);
    logic [31:0] inst;
    int vcyc, nvalid, nbeats;
    logic [31:0] base;
    do_fetch(pc, fence_cyc, lat, inst, vcyc, nvalid, nbeats);
    if (miss) exp_miss++; else exp_hits++;
    check32({name, " valid_pulses"}, 32'(nvalid), 32'd1);
    check32({name, " inst"}, inst, exp_inst);
    check32({name, " beats"}, 32'(nbeats), miss ? 32'(LW) : 32'd0);
    check32({name, " latency"}, 32'(vcyc), miss ? 32'(LW * (lat + 1) + 1) : 32'd1);
    if (miss) begin
      base = pc & ~32'(LW * 4 - 1);
      for (int i = 0; i < LW; i++) begin
        check32({name, " araddr"}, (addr_q.size() > i) ? addr_q[i] : 32'hFFFF_FFFF,
                base + 32'(4 * i));
      end
    end
    check32({name, " hit_cnt"}, hit_cnt_o, 32'(exp_hits));
    check32({name, " miss_cnt"}, miss_cnt_o, 32'(exp_miss));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    ifu_req = 1'b0;
    fence_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_hits = 0;
    exp_miss = 0;
  endtask

  typedef struct {
    logic [31:0] pc;
    bit          pre_fence;
    int          fence_cyc;
    int          lat;
    bit          miss;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[14];

  bit          m_valid[SETS];
  logic [23:0] m_tag[SETS];

  initial begin
    vecs[0]  = '{32'h8000_0004, 0, -1, 3, 1, 32'h0000_0022};  // cold miss
    vecs[1]  = '{32'h8000_000C, 0, -1, 3, 0, 32'h0000_0044};  // hit same line
    vecs[2]  = '{32'h8000_0000, 0, -1, 1, 0, 32'h0000_0011};
    vecs[3]  = '{32'h8000_0100, 0, -1, 1, 1, 32'hDA5A_1334};  // conflict evicts
    vecs[4]  = '{32'h8000_0000, 0, -1, 1, 1, 32'h0000_0011};
    vecs[5]  = '{32'h8000_0100, 0, -1, 1, 1, 32'hDA5A_1334};
    vecs[6]  = '{32'h8000_0008, 0, -1, 2, 1, 32'h0000_0033};
    vecs[7]  = '{32'h8000_0008, 0, -1, 2, 0, 32'h0000_0033};
    vecs[8]  = '{32'h8000_0008, 1, -1, 0, 1, 32'h0000_0033};  // fence before refetch
    vecs[9]  = '{32'h8000_0200, 0, 10, 3, 1, 32'hDA5A_1034};  // fence during beat 2
    vecs[10] = '{32'h8000_0200, 0, -1, 1, 1, 32'hDA5A_1034};  // poisoned line misses
    vecs[11] = '{32'h8000_0200, 0, -1, 1, 0, 32'hDA5A_1034};
    vecs[12] = '{32'h8000_0200, 0, 0, 1, 1, 32'hDA5A_1034};   // fence with lookup
    vecs[13] = '{32'h8000_0200, 0, -1, 1, 0, 32'hDA5A_1034};

    repeat (3) @(negedge clk);
    #1;
    check32("reset valid", {31'b0, ifu_valid_o}, 32'd0);
    check32("reset arvalid", {31'b0, bus_arvalid_o}, 32'd0);
    check32("reset araddr", bus_araddr_o, 32'd0);
    check32("reset inst", ifu_inst_o, 32'd0);
    check32("reset hit_cnt", hit_cnt_o, 32'd0);
    check32("reset miss_cnt", miss_cnt_o, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].pre_fence) pulse_fence();
      fetch_and_check($sformatf("vec%0d", i), vecs[i].pc, vecs[i].fence_cyc, vecs[i].lat,
                      vecs[i].miss, vecs[i].inst);
    end

    // Request held through RESP with a new pc: one pulse per request.
    begin
      int nval = 0, c1 = 0, c2 = 0;
      logic [31:0] i1 = '0, i2 = '0;
      @(negedge clk);
      ifu_pc  = 32'h8000_0200;
      ifu_req = 1'b1;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (ifu_valid_o) begin
          nval++;
          if (nval == 1) begin i1 = ifu_inst_o; c1 = c; ifu_pc = 32'h8000_0204; end
          if (nval == 2) begin i2 = ifu_inst_o; c2 = c; ifu_req = 1'b0; end
        end
      end
      ifu_req = 1'b0;
      exp_hits += 2;
      check32("held pulses", 32'(nval), 32'd2);
      check32("held inst1", i1, 32'hDA5A_1034);
      check32("held inst2", i2, 32'hDA5A_1030);
      check32("held spacing", 32'(c2 - c1), 32'd2);
      check32("held hit_cnt", hit_cnt_o, 32'(exp_hits));
    end

    // Hit counter wraps modulo 2^32.
    @(negedge clk);
    force dut.hit_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.hit_cnt;
    @(negedge clk);
    check32("wrap preload", hit_cnt_o, 32'hFFFF_FFFF);
    exp_hits = -1;
    fetch_and_check("wrap", 32'h8000_0200, -1, 1, 0, 32'hDA5A_1034);
    check32("wrap zero", hit_cnt_o, 32'h0000_0000);

    // Reset in the middle of a refill.
    begin
      int seen = 0;
      bus_lat = 3;
      beat_count = 0;
      @(negedge clk);
      ifu_pc  = 32'h8000_0300;
      ifu_req = 1'b1;
      for (int c = 0; c < 60 && beat_count < 1; c++) @(negedge clk);
      check32("midreset beat1 reached", 32'(beat_count >= 1), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      ifu_req = 1'b0;
      #1;
      check32("midreset arvalid", {31'b0, bus_arvalid_o}, 32'd0);
      check32("midreset araddr", bus_araddr_o, 32'd0);
      check32("midreset hit_cnt", hit_cnt_o, 32'd0);
      check32("midreset miss_cnt", miss_cnt_o, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      exp_hits = 0;
      exp_miss = 0;
      @(negedge clk);
      stray_req = 1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (ifu_valid_o || bus_arvalid_o) seen++;
      end
      check32("stray rvalid ignored", 32'(seen), 32'd0);
      fetch_and_check("after reset", 32'h8000_0200, -1, 1, 1, 32'hDA5A_1034);
    end

    // Randomized fetches against a behavioural direct-mapped model.
    apply_reset();
    for (int s = 0; s < SETS; s++) m_valid[s] = 0;
    for (int n = 0; n < 150; n++) begin
      logic [31:0] pc;
      int idx, mode, fc, lat;
      bit miss;
      idx  = int'($urandom_range(0, 3));
      pc   = 32'h8000_0000 | (32'($urandom_range(0, 2)) << 8) | (32'(idx) << 4)
             | (32'($urandom_range(0, 3)) << 2);
      mode = int'($urandom_range(0, 9));
      lat  = int'($urandom_range(0, 3));
      fc   = -1;
      if (mode == 9) begin
        pulse_fence();
        for (int s = 0; s < SETS; s++) m_valid[s] = 0;
      end
      miss = !(m_valid[idx] && m_tag[idx] == pc[31:8]);
      if (mode == 8) begin
        fc = 0;
        miss = 1;
      end else if (mode == 7 && miss) begin
        fc = int'($urandom_range(1, 4));
      end
      if (fc >= 0) for (int s = 0; s < SETS; s++) m_valid[s] = 0;
      fetch_and_check($sformatf("rand%0d", n), pc, fc, lat, miss, mem_word(pc));
      if (miss) begin
        m_tag[idx]   = pc[31:8];
        m_valid[idx] = (fc <= 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
